beep_song_ctrl: RTL and testbench

//   Sequences song playback for the PWM beeper tone generator.
//   - Walks a note table in external ROM and presents each note's period (system clocks) and enable to the tone generator.
//   - Times each note in duration ticks and inserts an articulation gap between notes.
//   - Handles play/pause/stop, looping, and an end-of-song marker.

---
 rtl/beep_song_ctrl.sv | 162 ++++++++++++++++
 tb/tb_beep_song_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/beep_song_ctrl.sv
// beep_song_ctrl: walks a note table and drives the PWM beeper tone generator.
// Ports: clk/rst, play/pause/stop/loop_en/start_addr in, rom_addr/rom_data table
//        read, tone_period/tone_en to the tone generator, busy/song_done status.
module beep_song_ctrl #(
  parameter int TICK_DIV  = 250000,
  parameter int GAP_TICKS = 2,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [24:0]       rom_data,
  output logic [16:0]       tone_period,
  output logic              tone_en,
  output logic              busy,
  output logic              song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_PAUSED,
    S_DONE
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [7:0] GAP8 = 8'(GAP_TICKS);

  state_t            r_state;
  state_t            w_next;
  state_t            r_resume;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_start;
  logic [7:0]        r_rem;
  logic [TW-1:0]     r_tick;
  logic [16:0]       r_period;
  logic              r_en;
  logic              r_song_done;

  logic [7:0]  w_dur;
  logic [16:0] w_per;
  logic        w_run;
  logic        w_tick;
  logic [7:0]  w_rem_dec;

  assign w_dur     = rom_data[7:0];
  assign w_per     = rom_data[24:8];
  // A pause or stop in this cycle freezes the tick phase and the
  // remaining count, so a resumed note finishes exactly on schedule.
  assign w_run     = ((r_state == S_PLAY) || (r_state == S_GAP))
                     && !stop && !pause;
  assign w_tick    = w_run && (r_tick == TICK_MAX);
  assign w_rem_dec = r_rem - 8'd1;

  // The pointer drives the table directly: it is stable throughout
  // FETCH so the table's registered read is ready during LOAD.
  assign rom_addr  = r_ptr;
  assign song_done = r_song_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (stop) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: if (play) w_next = S_FETCH;
        S_FETCH: w_next = S_LOAD;
        S_LOAD: begin
          if (w_dur == 8'd0) w_next = loop_en ? S_FETCH : S_DONE;
          else               w_next = S_PLAY;
        end
        S_PLAY: begin
          if (pause) begin
            w_next = S_PAUSED;
          end else if (w_tick) begin
            // Zero is tested first so GAP_TICKS=0 gives legato notes;
            // notes no longer than the gap never reach the gap count.
            if (w_rem_dec == 8'd0)  w_next = S_FETCH;
            else if (w_rem_dec == GAP8) w_next = S_GAP;
          end
        end
        S_GAP: begin
          if (pause) w_next = S_PAUSED;
          else if (w_tick && (w_rem_dec == 8'd0)) w_next = S_FETCH;
        end
        S_PAUSED: if (play) w_next = r_resume;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tone_period = 17'd0;
    tone_en     = 1'b0;
    busy        = 1'b1;
    if (r_state == S_PLAY) begin
      tone_period = r_period;
      tone_en     = r_en;
    end
    if ((r_state == S_IDLE) || (r_state == S_DONE)) busy = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resume    <= S_IDLE;
      r_ptr       <= '0;
      r_start     <= '0;
      r_rem       <= '0;
      r_tick      <= '0;
      r_period    <= '0;
      r_en        <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_song_done <= (r_state == S_LOAD) && (w_dur == 8'd0)
                     && !loop_en && !stop;
      if (w_run) r_tick <= w_tick ? '0 : r_tick + TW'(1);
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (play && !stop) begin
            r_ptr   <= start_addr;
            r_start <= start_addr;
          end
        end
        S_LOAD: begin
          if (!stop) begin
            if (w_dur == 8'd0) begin
              if (loop_en) r_ptr <= r_start;
            end else begin
              r_rem    <= w_dur;
              r_period <= w_per;
              r_en     <= (w_per != 17'd0);
              r_tick   <= '0;
            end
          end
        end
        S_PLAY, S_GAP: begin
          if (w_tick) begin
            r_rem <= w_rem_dec;
            if (w_rem_dec == 8'd0) r_ptr <= r_ptr + ADDR_W'(1);
          end
          if (pause && !stop) r_resume <= r_state;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_beep_song_ctrl.sv
// tb_beep_song_ctrl: directed checks of beep_song_ctrl with a small note table.
// Two instances share stimulus: gap of 1 tick (main) and 2 ticks (short-note case).
module tb_beep_song_ctrl;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          play;
  logic          pause;
  logic          stop;
  logic          loop_en;
  logic [AW-1:0] start_addr;

  logic [AW-1:0] rom_addr;
  logic [24:0]   rom_data;
  logic [16:0]   tone_period;
  logic          tone_en;
  logic          busy;
  logic          song_done;

  logic [AW-1:0] rom_addr2;
  logic [24:0]   rom_data2;
  logic [16:0]   tone_period2;
  logic          tone_en2;
  logic          busy2;
  logic          song_done2;

  logic [24:0] rom [0:15];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  beep_song_ctrl #(.TICK_DIV(4), .GAP_TICKS(1), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .loop_en(loop_en), .start_addr(start_addr), .rom_addr(rom_addr),
    .rom_data(rom_data), .tone_period(tone_period), .tone_en(tone_en),
    .busy(busy), .song_done(song_done)
  );

  beep_song_ctrl #(.TICK_DIV(4), .GAP_TICKS(2), .ADDR_W(AW)) u_dut2 (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .loop_en(loop_en), .start_addr(start_addr), .rom_addr(rom_addr2),
    .rom_data(rom_data2), .tone_period(tone_period2), .tone_en(tone_en2),
    .busy(busy2), .song_done(song_done2)
  );

  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    rom_data2 <= rom[rom_addr2];
  end

  always @(posedge clk) if (song_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_play();
    play = 1'b1;
    cyc(1);
    play = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  initial begin
    int n;
    int nz;
    int d0;
    for (int i = 0; i < 16; i++) rom[i] = 25'd0;
    rom[0] = {17'd47801, 8'd3};
    rom[1] = {17'd0,     8'd2};
    rom[2] = {17'd123,   8'd0};
    rom[4] = {17'd1000,  8'd1};
    rom[5] = {17'd7,     8'd0};
    rom[8] = {17'd2000,  8'd3};
    rom[9] = {17'd9,     8'd0};

    rst = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0;
    loop_en = 1'b0; start_addr = '0;
    cyc(3);
    chk("rst_period", 32'(tone_period), 0);
    chk("rst_en", 32'(tone_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_done", 32'(song_done), 0);
    rst = 1'b0;
    cyc(1);

    // 1: one note with gap, one rest, end marker
    pulse_play();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_fetch_mute", 32'(tone_en), 0);
    cyc(2);
    chk("t1_period", 32'(tone_period), 47801);
    chk("t1_en", 32'(tone_en), 1);
    cyc(7);
    chk("t1_late_period", 32'(tone_period), 47801);
    cyc(1);
    chk("t1_gap_en", 32'(tone_en), 0);
    chk("t1_gap_period", 32'(tone_period), 0);
    chk("t1_gap_busy", 32'(busy), 1);
    cyc(4);
    chk("t1_next_addr", 32'(rom_addr), 1);
    cyc(2);
    chk("t1_rest_en", 32'(tone_en), 0);
    chk("t1_rest_busy", 32'(busy), 1);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (song_done) begin
        n = i;
        break;
      end
    end
    chk("t1_done_lat", 32'(n), 9);
    chk("t1_done_busy", 32'(busy), 0);
    cyc(1);
    chk("t1_done_pulse", 32'(song_done), 0);

    // 2: loop back to start instead of finishing
    loop_en = 1'b1;
    d0 = done_cnt;
    pulse_play();
    cyc(25);
    chk("t2_addr_end", 32'(rom_addr), 2);
    cyc(1);
    chk("t2_addr_wrap", 32'(rom_addr), 0);
    chk("t2_busy", 32'(busy), 1);
    cyc(2);
    chk("t2_replay", 32'(tone_period), 47801);
    chk("t2_no_done", 32'(done_cnt - d0), 0);
    pulse_stop();
    chk("t2_stop_busy", 32'(busy), 0);
    loop_en = 1'b0;

    // 3: pause with 2 ticks left (play+pause together: pause wins)
    pulse_play();
    cyc(7);
    chk("t3_pre_pause", 32'(tone_period), 47801);
    play = 1'b1; pause = 1'b1;
    cyc(1);
    play = 1'b0; pause = 1'b0;
    chk("t3_pause_en", 32'(tone_en), 0);
    chk("t3_pause_period", 32'(tone_period), 0);
    chk("t3_pause_busy", 32'(busy), 1);
    nz = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (tone_en || (tone_period != 17'd0) || (rom_addr != '0)) nz++;
    end
    chk("t3_held_quiet", 32'(nz), 0);
    pulse_play();
    chk("t3_resume_period", 32'(tone_period), 47801);
    chk("t3_resume_en", 32'(tone_en), 1);
    cyc(2);
    chk("t3_still_on", 32'(tone_en), 1);
    cyc(1);
    chk("t3_gap_en", 32'(tone_en), 0);
    cyc(3);
    chk("t3_addr_hold", 32'(rom_addr), 0);
    cyc(1);
    chk("t3_addr_next", 32'(rom_addr), 1);
    pulse_stop();

    // 4: stop with play in the same cycle
    pulse_play();
    cyc(2);
    chk("t4_playing", 32'(tone_en), 1);
    play = 1'b1; stop = 1'b1;
    cyc(1);
    play = 1'b0; stop = 1'b0;
    chk("t4_en", 32'(tone_en), 0);
    chk("t4_period", 32'(tone_period), 0);
    chk("t4_busy", 32'(busy), 0);
    cyc(3);
    chk("t4_stay_idle", 32'(busy), 0);

    // 5: one-tick note on the two-tick-gap instance
    start_addr = 4'd4;
    pulse_play();
    cyc(2);
    chk("t5_period", 32'(tone_period2), 1000);
    chk("t5_en", 32'(tone_en2), 1);
    cyc(3);
    chk("t5_full_tick", 32'(tone_en2), 1);
    cyc(1);
    chk("t5_off", 32'(tone_en2), 0);
    chk("t5_no_gap", 32'(rom_addr2), 5);
    cyc(3);
    chk("t5_done_busy", 32'(busy2), 0);

    // 6: reset during gap, then restart
    start_addr = 4'd8;
    pulse_play();
    cyc(10);
    chk("t6_gap_en", 32'(tone_en), 0);
    chk("t6_gap_busy", 32'(busy), 1);
    start_addr = 4'd3;
    cyc(1);
    chk("t6_addr_kept", 32'(rom_addr), 8);
    rst = 1'b1;
    cyc(1);
    chk("t6_rst_period", 32'(tone_period), 0);
    chk("t6_rst_en", 32'(tone_en), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_addr", 32'(rom_addr), 0);
    rst = 1'b0;
    start_addr = 4'd8;
    pulse_play();
    chk("t6_restart_addr", 32'(rom_addr), 8);
    cyc(2);
    chk("t6_restart_period", 32'(tone_period), 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
